// File: rtl/instruction_fetch_responder.sv
// Fetch-side instruction memory: answers PC fetches after LATENCY wait states,
// stalls the PC while a fetch is outstanding, and accepts preload writes.
module instruction_fetch_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        resp_valid,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
  output logic        fetch_stall,
  output logic        fetch_fault
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          req_fault, load_ok;
  logic          rsp, rsp_fault, rsp_read;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rsp_addr;

  assign req_fault = (|req_addr[31:AW+2]) | (|req_addr[1:0]);
  assign load_ok   = ~(|load_addr[31:AW+2]) & ~(|load_addr[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rsp       = 1'b0;
    rsp_fault = 1'b0;
    rsp_read  = 1'b0;
    rsp_addr  = addr_q;
    rd_idx    = addr_q[AW+1:2];
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          addr_d   = req_addr;
          rsp_addr = req_addr;
          rd_idx   = req_addr[AW+1:2];
          if (req_fault) begin
            rsp       = 1'b1;
            rsp_fault = 1'b1;
          end else if (LATENCY == 0) begin
            rsp      = 1'b1;
            rsp_read = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          rsp      = 1'b1;
          rsp_read = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response registers; instr/addr hold between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid  <= 1'b0;
      fetch_fault <= 1'b0;
      resp_instr  <= 32'd0;
      resp_addr   <= 32'd0;
    end else begin
      resp_valid  <= rsp;
      fetch_fault <= rsp & rsp_fault;
      if (rsp) begin
        resp_addr  <= rsp_addr;
        resp_instr <= rsp_read ? mem[rd_idx] : NOP_WORD;
      end
    end
  end

  // Storage is never cleared; a same-edge read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (!reset && load_en && load_ok)
      mem[load_addr[AW+1:2]] <= load_data;
  end

  assign fetch_stall = (state_q == S_WAIT);
endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Directed bench: LATENCY=2 instance for fetch/stall/flush/reset, LATENCY=0
// instance for the zero-wait and same-edge preload cases.
module tb_instruction_fetch_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, flush, load_en;
  logic [31:0] req_addr, load_addr, load_data;
  logic        resp_valid, fetch_stall, fetch_fault;
  logic [31:0] resp_instr, resp_addr;

  logic        z_req_valid, z_flush, z_load_en;
  logic [31:0] z_req_addr, z_load_addr, z_load_data;
  logic        z_resp_valid, z_fetch_stall, z_fetch_fault;
  logic [31:0] z_resp_instr, z_resp_addr;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  instruction_fetch_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .resp_valid(resp_valid), .resp_instr(resp_instr), .resp_addr(resp_addr),
    .fetch_stall(fetch_stall), .fetch_fault(fetch_fault)
  );

  instruction_fetch_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_addr(z_req_addr),
    .flush(z_flush), .load_en(z_load_en), .load_addr(z_load_addr), .load_data(z_load_data),
    .resp_valid(z_resp_valid), .resp_instr(z_resp_instr), .resp_addr(z_resp_addr),
    .fetch_stall(z_fetch_stall), .fetch_fault(z_fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  // Single fetch on the LATENCY=2 instance, checking stall and response timing.
  task automatic fetch2(input string tag, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_addr = a;
    step();
    req_valid = 1'b0;
    chk({tag, "_stall_k"}, {31'd0, fetch_stall}, 32'd1);
    chk({tag, "_vld_k"},   {31'd0, resp_valid},  32'd0);
    step();
    chk({tag, "_stall_k1"}, {31'd0, fetch_stall}, 32'd1);
    chk({tag, "_vld_k1"},   {31'd0, resp_valid},  32'd0);
    step();
    chk({tag, "_vld_k2"},   {31'd0, resp_valid},  32'd1);
    chk({tag, "_instr"},    resp_instr, d);
    chk({tag, "_addr"},     resp_addr, a);
    chk({tag, "_fault"},    {31'd0, fetch_fault}, 32'd0);
    chk({tag, "_stall_k2"}, {31'd0, fetch_stall}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; flush = 0; load_en = 0; req_addr = 0; load_addr = 0; load_data = 0;
    z_req_valid = 0; z_flush = 0; z_load_en = 0; z_req_addr = 0; z_load_addr = 0; z_load_data = 0;
    step(); step();
    chk("rst_vld",   {31'd0, resp_valid},  32'd0);
    chk("rst_stall", {31'd0, fetch_stall}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_instr", resp_instr, 32'd0);
    chk("rst_addr",  resp_addr,  32'd0);
    reset = 1'b0;

    load(32'h0C, 32'h2008_0005);
    load(32'h00, 32'h1111_1111);
    load(32'h04, 32'h2222_2222);
    load(32'h08, 32'h3333_3333);
    load(32'h10, 32'h4444_4444);
    load(32'h14, 32'h5555_5555);

    fetch2("basic", 32'h0C, 32'h2008_0005);
    step();
    chk("pulse_end", {31'd0, resp_valid}, 32'd0);
    chk("instr_hold", resp_instr, 32'h2008_0005);

    // Back-to-back with req_valid held; addresses in WAIT must be ignored.
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, d;
      a = 32'(i * 4);
      d = (i == 0) ? 32'h1111_1111 : (i == 1) ? 32'h2222_2222 : 32'h3333_3333;
      req_addr = a;
      step();
      chk("b2b_stall", {31'd0, fetch_stall}, 32'd1);
      req_addr = 32'h0000_008C;
      step();
      chk("b2b_gap", {31'd0, resp_valid}, 32'd0);
      step();
      chk("b2b_vld",   {31'd0, resp_valid}, 32'd1);
      chk("b2b_instr", resp_instr, d);
      chk("b2b_addr",  resp_addr, a);
    end
    req_valid = 1'b0;
    step();
    chk("b2b_after", {31'd0, resp_valid}, 32'd0);

    // Faults respond at the accept edge with no wait.
    req_valid = 1'b1; req_addr = 32'h06;
    step();
    chk("mis_vld",   {31'd0, resp_valid},  32'd1);
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_instr", resp_instr, 32'h0);
    chk("mis_addr",  resp_addr, 32'h06);
    chk("mis_stall", {31'd0, fetch_stall}, 32'd0);
    req_addr = 32'h400;
    step();
    chk("oor_vld",   {31'd0, resp_valid},  32'd1);
    chk("oor_fault", {31'd0, fetch_fault}, 32'd1);
    chk("oor_instr", resp_instr, 32'h0);
    chk("oor_addr",  resp_addr, 32'h400);
    chk("oor_stall", {31'd0, fetch_stall}, 32'd0);
    req_valid = 1'b0;
    step();
    chk("flt_end", {31'd0, resp_valid}, 32'd0);

    // Flush in WAIT, then flush in IDLE blocks acceptance.
    req_valid = 1'b1; req_addr = 32'h10;
    step();
    req_valid = 1'b0; flush = 1'b1;
    chk("fl_acc_stall", {31'd0, fetch_stall}, 32'd1);
    step();
    flush = 1'b0;
    chk("fl_stall", {31'd0, fetch_stall}, 32'd0);
    chk("fl_vld",   {31'd0, resp_valid},  32'd0);
    step();
    chk("fl_vld2", {31'd0, resp_valid}, 32'd0);
    req_valid = 1'b1; req_addr = 32'h14; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    chk("fli_stall", {31'd0, fetch_stall}, 32'd0);
    chk("fli_vld",   {31'd0, resp_valid},  32'd0);
    fetch2("after_fl", 32'h14, 32'h5555_5555);

    // Reset during WAIT abandons the fetch; storage survives.
    req_valid = 1'b1; req_addr = 32'h0C;
    step();
    req_valid = 1'b0; reset = 1'b1;
    load_en = 1'b1; load_addr = 32'h0C; load_data = 32'hBAD0_BAD0;
    step();
    reset = 1'b0; load_en = 1'b0;
    chk("rw_vld",   {31'd0, resp_valid},  32'd0);
    chk("rw_stall", {31'd0, fetch_stall}, 32'd0);
    chk("rw_instr", resp_instr, 32'd0);
    chk("rw_addr",  resp_addr,  32'd0);
    step(); step();
    chk("rw_novld", {31'd0, resp_valid}, 32'd0);
    fetch2("post_rst", 32'h0C, 32'h2008_0005);

    // LATENCY=0: same-edge write/read returns old word; dropped loads.
    z_load_en = 1'b1; z_load_addr = 32'h20; z_load_data = 32'hCAFE_0001;
    step();
    z_load_data = 32'hDEAD_BEEF; z_req_valid = 1'b1; z_req_addr = 32'h20;
    step();
    z_load_en = 1'b0;
    chk("z_vld",   {31'd0, z_resp_valid},  32'd1);
    chk("z_old",   z_resp_instr, 32'hCAFE_0001);
    chk("z_stall", {31'd0, z_fetch_stall}, 32'd0);
    step();
    chk("z_new",    z_resp_instr, 32'hDEAD_BEEF);
    chk("z_vld2",   {31'd0, z_resp_valid},  32'd1);
    chk("z_fault",  {31'd0, z_fetch_fault}, 32'd0);
    chk("z_stall2", {31'd0, z_fetch_stall}, 32'd0);
    z_req_valid = 1'b0;
    z_load_en = 1'b1; z_load_addr = 32'h22; z_load_data = 32'h0BAD_0001;
    step();
    z_load_addr = 32'h420; z_load_data = 32'h0BAD_0002;
    step();
    z_load_en = 1'b0;
    chk("z_idle", {31'd0, z_resp_valid}, 32'd0);
    z_req_valid = 1'b1; z_req_addr = 32'h20;
    step();
    z_req_valid = 1'b0;
    chk("z_drop", z_resp_instr, 32'hDEAD_BEEF);
    chk("z_daddr", z_resp_addr, 32'h20);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
